// File: rtl/stream_demux_1xn_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package stream_demux_1xn_pkg;

    localparam int ERR_W_DEF = 8;
    localparam logic [ERR_W_DEF-1:0] ERR_MAX = '1;

    // Select width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry output holding register with valid/ready handshake.
module demux_out_slot
    import stream_demux_1xn_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              free
);

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    // A full slot that drains this cycle can take a new word at the same edge.
    assign free = !vld_p1 || out_ready;

    // Stage p1: held word; data keeps its stale value after a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= load_data;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N valid/ready demultiplexer with atomic broadcast and a
// saturating counter of words dropped for an out-of-range select.
module stream_demux_1xn
    import stream_demux_1xn_pkg::*;
#(
    parameter  int N_OUT  = 4,
    parameter  int DATA_W = 8,
    parameter  int ERR_W  = ERR_W_DEF,
    localparam int SEL_W  = clog2_min1(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam logic [ERR_W-1:0] ERR_SAT =
        (ERR_W == ERR_W_DEF) ? ERR_W'(ERR_MAX) : '1;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_SAT) ? v : v + ERR_W'(1);
    endfunction

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             accept;
    logic             drop;
    logic [ERR_W-1:0] err_p1;

    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sel_hit[i] = (in_sel == SEL_W'(i));
        end
    end

    assign sel_ok = |sel_hit;

    // An out-of-range select is always ready so the word can be discarded.
    always_comb begin
        in_ready = 1'b0;
        if (en && rst_n) begin
            if (in_bcast) begin
                in_ready = &free;
            end else if (sel_ok) begin
                in_ready = |(sel_hit & free);
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign accept = in_valid && in_ready;
    assign load   = {N_OUT{accept}} & (in_bcast ? {N_OUT{1'b1}} : sel_hit);
    assign drop   = accept && !in_bcast && !sel_ok;

    // Stage p1: per-channel holding registers.
    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_out_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[g]),
            .load_data(in_data),
            .out_ready(out_ready[g]),
            .out_valid(out_valid[g]),
            .out_data (out_data[g*DATA_W +: DATA_W]),
            .free     (free[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_p1 <= '0;
        end else if (drop) begin
            err_p1 <= sat_inc(err_p1);
        end
    end

    assign err_cnt = err_p1;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Scoreboard bench for stream_demux_1xn (N_OUT=4 random/directed, N_OUT=3 drop path).
module tb_stream_demux_1xn;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int EW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, en, in_valid, in_bcast, in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic [N-1:0]    out_valid, out_ready;
    logic [N*DW-1:0] out_data;
    logic [EW-1:0]   err_cnt;

    logic            en3, in_valid3, in_bcast3, in_ready3;
    logic [7:0]      in_data3;
    logic [1:0]      in_sel3;
    logic [2:0]      out_valid3, out_ready3;
    logic [23:0]     out_data3;
    logic [7:0]      err_cnt3;

    stream_demux_1xn #(.N_OUT(N), .DATA_W(DW), .ERR_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err_cnt(err_cnt)
    );

    stream_demux_1xn #(.N_OUT(3), .DATA_W(8), .ERR_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .err_cnt(err_cnt3)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words accepted but not yet consumed, per channel.
    logic [DW-1:0] q[N][$];
    bit            mon_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        logic [N-1:0] fr;
        for (int i = 0; i < N; i++) fr[i] = (q[i].size() == 0) || out_ready[i];
        if (!en || !rst_n) return 1'b0;
        if (in_bcast) return &fr;
        if (int'(in_sel) < N) return fr[in_sel];
        return 1'b1;
    endfunction

    // One clock of stimulus: check ready, then record what the edge accepts.
    task automatic step();
        logic acc;
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = model_ready();
        check("in_ready", in_ready, exp_rdy);
        acc = in_valid && exp_rdy;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) q[i].delete();
        end else if (acc) begin
            if (in_bcast) begin
                for (int i = 0; i < N; i++) q[i].push_back(in_data);
            end else if (int'(in_sel) < N) begin
                q[in_sel].push_back(in_data);
            end
        end
        #1;
    endtask

    // Monitor: occupancy, ordered delivery, stall stability, error counter.
    logic [N-1:0]    pv, pr;
    logic [N*DW-1:0] pd;
    logic            p_rst;
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("valid%0d", i), out_valid[i], q[i].size() != 0);
                if (p_rst && pv[i] && !pr[i]) begin
                    check($sformatf("stall_vld%0d", i), out_valid[i], 1'b1);
                    check($sformatf("stall_dat%0d", i), out_data[i*DW +: DW], pd[i*DW +: DW]);
                end
                if (out_valid[i] && out_ready[i] && q[i].size() != 0) begin
                    check($sformatf("data%0d", i), out_data[i*DW +: DW], q[i][0]);
                    void'(q[i].pop_front());
                end
            end
            check("err_cnt", err_cnt, 0);
        end
        pv    = out_valid;
        pr    = out_ready;
        pd    = out_data;
        p_rst = rst_n;
    end

    initial begin
        int exp3;
        int s;
        logic [7:0] d;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_bcast = 1'b0;
        in_sel = 2'd0; in_data = 8'h00; out_ready = '1;
        en3 = 1'b0; in_valid3 = 1'b0; in_bcast3 = 1'b0; in_sel3 = 2'd0;
        in_data3 = 8'h00; out_ready3 = 3'b111;

        // Reset: in_ready low while held, then clean outputs.
        step(); step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", err_cnt, 0);
        mon_on = 1'b1;
        rst_n  = 1'b1;

        // Unicast with 1-cycle latency, then drain leaving stale data.
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b1111;
        step();
        check("t1_valid", out_valid, 4'b0100);
        check("t1_data", out_data[23:16], 8'hA5);
        in_valid = 1'b0;
        step();
        check("t1_drain", out_valid, 4'b0000);
        check("t1_stale", out_data[23:16], 8'hA5);

        // Backpressure on channel 1.
        out_ready = 4'b1101; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        step();
        check("t2_hold", out_data[15:8], 8'h11);
        out_ready = 4'b1111;
        step();
        check("t2_valid", out_valid, 4'b0010);
        check("t2_data", out_data[15:8], 8'h22);
        in_valid = 1'b0;
        step();

        // Broadcast waits for every slot, then lands atomically.
        out_ready = 4'b1011; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h77;
        step();
        in_bcast = 1'b1; in_data = 8'h3C;
        step();
        check("t3_blocked", out_valid, 4'b0100);
        check("t3_keep", out_data[23:16], 8'h77);
        out_ready = 4'b1111;
        step();
        check("t3_valid", out_valid, 4'b1111);
        check("t3_data", out_data, {4{8'h3C}});
        in_valid = 1'b0; in_bcast = 1'b0;
        step();

        // Channel 0 stalled full; channels 1 and 3 keep flowing.
        out_ready = 4'b1110; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h05;
        step();
        for (int k = 0; k < 8; k++) begin
            s = (k % 2) ? 3 : 1;
            d = 8'($urandom);
            in_sel = 2'(s); in_data = d;
            step();
            check("t4_valid", out_valid[s], 1'b1);
            check("t4_data", out_data[s*DW +: DW], d);
            check("t4_stall0", out_data[7:0], 8'h05);
        end
        out_ready = 4'b1111; in_valid = 1'b0;
        step(); step();

        // en low: no accepts while slots keep draining.
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h9E; out_ready = 4'b0000;
        step();
        en = 1'b0; out_ready = 4'b1111;
        step(); step();
        check("t6_en_drain", out_valid, 4'b0000);
        en = 1'b1;

        // Reset with every slot full.
        out_ready = 4'b0000; in_bcast = 1'b1; in_data = 8'hE7;
        step();
        check("t6_full", out_valid, 4'b1111);
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_err", err_cnt, 0);
        rst_n = 1'b1; in_bcast = 1'b0;

        // Randomized traffic against the scoreboard.
        for (int k = 0; k < 1500; k++) begin
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bcast  = ($urandom_range(0, 7) == 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom) | 4'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 4'b1111;
        step(); step();

        // N_OUT=3: unicast, broadcast, then out-of-range select saturation.
        en3 = 1'b1; in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h5A;
        @(posedge clk); #1;
        check("n3_uni_valid", out_valid3, 3'b100);
        check("n3_uni_data", out_data3[23:16], 8'h5A);
        in_bcast3 = 1'b1; in_data3 = 8'hC3;
        @(posedge clk); #1;
        check("n3_bc_valid", out_valid3, 3'b111);
        check("n3_bc_data", out_data3, {3{8'hC3}});
        in_valid3 = 1'b0; in_bcast3 = 1'b0;
        @(posedge clk); #1;
        in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'hFF;
        exp3 = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            check("n3_ready", in_ready3, 1'b1);
            check("n3_no_valid", out_valid3, 3'b000);
            @(posedge clk);
            exp3 = (exp3 == 255) ? 255 : exp3 + 1;
            #1;
            check("n3_err", err_cnt3, exp3);
        end
        check("n3_err_sat", err_cnt3, 8'd255);
        in_valid3 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
